// File: rtl/acc_pkg.sv
// Shared types and default widths for the EX2 multiply-accumulate back end.
package acc_pkg;

  localparam int ACC_DW   = 32;
  localparam int ACC_NACC = 4;

  typedef enum logic [3:0] {
    NOP   = 4'd0,
    MULT  = 4'd1,
    MADD  = 4'd2,
    MADDU = 4'd3,
    MSUB  = 4'd4,
    MSUBU = 4'd5,
    MTHI  = 4'd6,
    MTLO  = 4'd7,
    MFHI  = 4'd8,
    MFLO  = 4'd9,
    CLR   = 4'd10
  } acc_op_t;

  // Unassigned encodings behave like NOP and never enter the pipeline.
  function automatic logic op_is_issuable(acc_op_t op);
    return op inside {MULT, MADD, MADDU, MSUB, MSUBU, MTHI, MTLO, MFHI, MFLO, CLR};
  endfunction

endpackage

// File: rtl/acc_mac_unit_if.sv
// Request/response bundle between the EX1 multiplier, the MAC back end and the EX2 muxes.
interface acc_mac_unit_if
  import acc_pkg::*;
#(
  parameter int DW   = ACC_DW,
  parameter int NACC = ACC_NACC
);
  localparam int AW = (NACC > 1) ? $clog2(NACC) : 1;

  logic            InValid;
  logic            InReady;
  acc_op_t         Op;
  logic [AW-1:0]   AccSel;
  logic [2*DW-1:0] In;
  logic            OutValid;
  logic            OutReady;
  logic [DW-1:0]   Out;
  logic            C;
  logic            Z;
  logic            O;
  logic            N;
  logic            Busy;

  modport master (
    output InValid, Op, AccSel, In, OutReady,
    input  InReady, OutValid, Out, C, Z, O, N, Busy
  );

  modport slave (
    input  InValid, Op, AccSel, In, OutReady,
    output InReady, OutValid, Out, C, Z, O, N, Busy
  );

endinterface

// File: rtl/acc_addsub.sv
// Combinational accumulator adder/subtractor with signed/unsigned status and optional clamping.
module acc_addsub #(
  parameter int W   = 64,
  parameter int SAT = 0
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  input  logic         is_signed,
  output logic [W-1:0] res,
  output logic         c,
  output logic         o
);

  logic [W:0] raw;
  logic       ovf;

  always_comb begin
    raw = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    ovf = sub ? ((a[W-1] != b[W-1]) && (raw[W-1] != a[W-1]))
              : ((a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]));
    c   = !is_signed && raw[W];
    o   = is_signed && ovf;
    res = raw[W-1:0];
    if (SAT != 0) begin
      // Signed overflow always leaves the result on the side of a's sign, add or subtract.
      if (o)      res = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      else if (c) res = sub ? '0 : '1;
    end
  end

endmodule

// File: rtl/acc_mac_unit.sv
// Two-stage EX2 multiply-accumulate back end: NACC HI/LO accumulators, forwarding, CZON flags.
module acc_mac_unit
  import acc_pkg::*;
#(
  parameter int DW   = ACC_DW,
  parameter int NACC = ACC_NACC,
  parameter int SAT  = 0
) (
  input logic           Clock,
  input logic           Reset,
  acc_mac_unit_if.slave bus
);

  localparam int AW   = (NACC > 1) ? $clog2(NACC) : 1;
  localparam int AccW = 2 * DW;

  logic            stall, accept, req_ok;
  logic            s1_valid_q, s1_valid_d;
  acc_op_t         s1_op_q, s1_op_d;
  logic [AW-1:0]   s1_sel_q, s1_sel_d;
  logic [AccW-1:0] s1_in_q, s1_in_d;
  logic [AccW-1:0] s1_acc_q, s1_acc_d;
  logic            s2_valid_q, s2_valid_d;
  logic [DW-1:0]   out_q, out_d;
  logic            c_q, c_d, z_q, z_d, o_q, o_d, n_q, n_d;
  logic [AccW-1:0] acc_q [NACC];
  logic [AccW-1:0] acc_d [NACC];
  logic [AccW-1:0] acc_new, acc_rd, as_res;
  logic [DW-1:0]   res_word;
  logic            wr_op, wr_en, arith;
  logic            as_sub, as_signed, as_c, as_o;

  assign stall  = s2_valid_q && !bus.OutReady;
  assign accept = bus.InValid && !stall;
  assign req_ok = accept && op_is_issuable(bus.Op) && (int'(bus.AccSel) < NACC);

  assign as_sub    = s1_op_q inside {MSUB, MSUBU};
  assign as_signed = s1_op_q inside {MADD, MSUB};

  acc_addsub #(
    .W  (AccW),
    .SAT(SAT)
  ) u_addsub (
    .a        (s1_acc_q),
    .b        (s1_in_q),
    .sub      (as_sub),
    .is_signed(as_signed),
    .res      (as_res),
    .c        (as_c),
    .o        (as_o)
  );

  // Second stage: next accumulator value, result word and flags for the op held in S1.
  always_comb begin
    acc_new = s1_acc_q;
    wr_op   = 1'b1;
    arith   = 1'b0;
    unique case (s1_op_q)
      MULT:                     acc_new = s1_in_q;
      MADD, MADDU, MSUB, MSUBU: begin
        acc_new = as_res;
        arith   = 1'b1;
      end
      MTHI:                     acc_new = {s1_in_q[DW-1:0], s1_acc_q[DW-1:0]};
      MTLO:                     acc_new = {s1_acc_q[AccW-1:DW], s1_in_q[DW-1:0]};
      CLR:                      acc_new = '0;
      default:                  wr_op = 1'b0;
    endcase

    unique case (s1_op_q)
      MFHI:    res_word = s1_acc_q[AccW-1:DW];
      MFLO:    res_word = s1_acc_q[DW-1:0];
      default: res_word = acc_new[DW-1:0];
    endcase
  end

  assign wr_en = s1_valid_q && !stall && wr_op;

  // Operand read for the incoming request, bypassing the value S2 is writing this edge.
  always_comb begin
    acc_rd = '0;
    for (int unsigned i = 0; i < NACC; i++) begin
      if (AW'(i) == bus.AccSel) acc_rd = acc_q[i];
    end
    if (wr_en && (s1_sel_q == bus.AccSel)) acc_rd = acc_new;
  end

  always_comb begin
    for (int unsigned i = 0; i < NACC; i++) begin
      acc_d[i] = acc_q[i];
      if (wr_en && (AW'(i) == s1_sel_q)) acc_d[i] = acc_new;
    end
  end

  always_comb begin
    s1_valid_d = stall ? s1_valid_q : req_ok;
    s1_op_d    = s1_op_q;
    s1_sel_d   = s1_sel_q;
    s1_in_d    = s1_in_q;
    s1_acc_d   = s1_acc_q;
    if (req_ok) begin
      s1_op_d  = bus.Op;
      s1_sel_d = bus.AccSel;
      s1_in_d  = bus.In;
      s1_acc_d = acc_rd;
    end

    s2_valid_d = stall ? s2_valid_q : s1_valid_q;
    out_d      = out_q;
    c_d        = c_q;
    z_d        = z_q;
    o_d        = o_q;
    n_d        = n_q;
    if (s1_valid_q && !stall) begin
      out_d = res_word;
      if (arith) begin
        c_d = as_c;
        o_d = as_o;
        z_d = (acc_new == '0);
        n_d = acc_new[AccW-1];
      end else begin
        c_d = 1'b0;
        o_d = 1'b0;
        z_d = (res_word == '0);
        n_d = res_word[DW-1];
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= NOP;
      s1_sel_q   <= '0;
      s1_in_q    <= '0;
      s1_acc_q   <= '0;
      s2_valid_q <= 1'b0;
      out_q      <= '0;
      c_q        <= 1'b0;
      z_q        <= 1'b0;
      o_q        <= 1'b0;
      n_q        <= 1'b0;
      for (int unsigned i = 0; i < NACC; i++) acc_q[i] <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_sel_q   <= s1_sel_d;
      s1_in_q    <= s1_in_d;
      s1_acc_q   <= s1_acc_d;
      s2_valid_q <= s2_valid_d;
      out_q      <= out_d;
      c_q        <= c_d;
      z_q        <= z_d;
      o_q        <= o_d;
      n_q        <= n_d;
      for (int unsigned i = 0; i < NACC; i++) acc_q[i] <= acc_d[i];
    end
  end

  assign bus.InReady  = !stall;
  assign bus.OutValid = s2_valid_q;
  assign bus.Out      = out_q;
  assign bus.C        = c_q;
  assign bus.Z        = z_q;
  assign bus.O        = o_q;
  assign bus.N        = n_q;
  assign bus.Busy     = s1_valid_q || s2_valid_q;

endmodule

// File: tb/tb_acc_mac_unit.sv
// Directed bench for acc_mac_unit: a wrapping and a saturating instance driven with identical stimulus.
module tb_acc_mac_unit;
  import acc_pkg::*;

  localparam int DW   = 32;
  localparam int NACC = 3;
  localparam int AW   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  acc_mac_unit_if #(.DW(DW), .NACC(NACC)) bus0 ();
  acc_mac_unit_if #(.DW(DW), .NACC(NACC)) bus1 ();

  acc_mac_unit #(.DW(DW), .NACC(NACC), .SAT(0)) dut0 (.Clock(clk), .Reset(rst), .bus(bus0.slave));
  acc_mac_unit #(.DW(DW), .NACC(NACC), .SAT(1)) dut1 (.Clock(clk), .Reset(rst), .bus(bus1.slave));

  acc_op_t     fw_op  [4] = '{MULT, MADD, MFLO, MFHI};
  logic [63:0] fw_in  [4] = '{64'h0000_0001_0000_0000, 64'd1, 64'd0, 64'd0};
  logic [31:0] fw_out [4] = '{32'h0, 32'h1, 32'h1, 32'h1};
  logic [3:0]  fw_fl  [4] = '{4'b0100, 4'b0000, 4'b0000, 4'b0000};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] flg0();
    return {bus0.C, bus0.Z, bus0.O, bus0.N};
  endfunction

  function automatic logic [3:0] flg1();
    return {bus1.C, bus1.Z, bus1.O, bus1.N};
  endfunction

  task automatic drive(input logic v, input acc_op_t op, input logic [AW-1:0] sel, input logic [63:0] din);
    bus0.InValid = v; bus0.Op = op; bus0.AccSel = sel; bus0.In = din;
    bus1.InValid = v; bus1.Op = op; bus1.AccSel = sel; bus1.In = din;
  endtask

  task automatic set_ready(input logic r);
    bus0.OutReady = r;
    bus1.OutReady = r;
  endtask

  // Flags are packed {C,Z,O,N}; e0/f0 belong to the wrapping unit, e1/f1 to the clamping unit.
  task automatic do_op(input string tag, input acc_op_t op, input logic [AW-1:0] sel, input logic [63:0] din,
                       input logic [31:0] e0, input logic [3:0] f0, input logic [31:0] e1, input logic [3:0] f1);
    @(negedge clk);
    drive(1'b1, op, sel, din);
    @(negedge clk);
    drive(1'b0, NOP, '0, '0);
    chk($sformatf("%s.lat", tag), bus0.OutValid, 1'b0);
    @(negedge clk);
    chk($sformatf("%s.v0", tag), bus0.OutValid, 1'b1);
    chk($sformatf("%s.out0", tag), bus0.Out, e0);
    chk($sformatf("%s.fl0", tag), flg0(), f0);
    chk($sformatf("%s.v1", tag), bus1.OutValid, 1'b1);
    chk($sformatf("%s.out1", tag), bus1.Out, e1);
    chk($sformatf("%s.fl1", tag), flg1(), f1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b0, NOP, '0, '0);
    set_ready(1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    chk("rst.ov0", bus0.OutValid, 1'b0);
    chk("rst.busy0", bus0.Busy, 1'b0);
    chk("rst.rdy0", bus0.InReady, 1'b1);
    chk("rst.out0", bus0.Out, 32'h0);
    chk("rst.fl0", flg0(), 4'b0000);
    chk("rst.ov1", bus1.OutValid, 1'b0);

    // Back-to-back stream on acc0 exercising the S2->S1 bypass.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i >= 2 && i < 6) begin
        chk($sformatf("fw%0d.v", i - 2), bus0.OutValid, 1'b1);
        chk($sformatf("fw%0d.out0", i - 2), bus0.Out, fw_out[i-2]);
        chk($sformatf("fw%0d.fl0", i - 2), flg0(), fw_fl[i-2]);
        chk($sformatf("fw%0d.out1", i - 2), bus1.Out, fw_out[i-2]);
      end else if (i >= 1) begin
        chk($sformatf("fw.idle%0d", i), bus0.OutValid, 1'b0);
      end
      if (i < 4) drive(1'b1, fw_op[i], 2'd0, fw_in[i]);
      else       drive(1'b0, NOP, '0, '0);
    end
    chk("fw.busy", bus0.Busy, 1'b0);

    // Signed overflow on acc1.
    do_op("mtlo1", MTLO, 2'd1, 64'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b0001, 32'hFFFF_FFFF, 4'b0001);
    do_op("mthi1", MTHI, 2'd1, 64'h7FFF_FFFF, 32'hFFFF_FFFF, 4'b0001, 32'hFFFF_FFFF, 4'b0001);
    do_op("madd1", MADD, 2'd1, 64'd1, 32'h0, 4'b0011, 32'hFFFF_FFFF, 4'b0010);
    do_op("mfhi1", MFHI, 2'd1, 64'd0, 32'h8000_0000, 4'b0001, 32'h7FFF_FFFF, 4'b0000);
    do_op("mflo1", MFLO, 2'd1, 64'd0, 32'h0, 4'b0100, 32'hFFFF_FFFF, 4'b0001);

    // Unsigned borrow on acc2.
    do_op("clr2", CLR, 2'd2, 64'd0, 32'h0, 4'b0100, 32'h0, 4'b0100);
    do_op("msubu2", MSUBU, 2'd2, 64'd5, 32'hFFFF_FFFB, 4'b1001, 32'h0, 4'b1100);
    do_op("mfhi2", MFHI, 2'd2, 64'd0, 32'hFFFF_FFFF, 4'b0001, 32'h0, 4'b0100);

    // Signed subtract, unsigned carry and negative signed clamp on acc0.
    do_op("mult0a", MULT, 2'd0, 64'd10, 32'd10, 4'b0000, 32'd10, 4'b0000);
    do_op("msub0", MSUB, 2'd0, 64'd3, 32'd7, 4'b0000, 32'd7, 4'b0000);
    do_op("mult0b", MULT, 2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 4'b0001, 32'hFFFF_FFFF, 4'b0001);
    do_op("maddu0", MADDU, 2'd0, 64'd2, 32'h1, 4'b1000, 32'hFFFF_FFFF, 4'b1001);
    do_op("mult0c", MULT, 2'd0, 64'h8000_0000_0000_0000, 32'h0, 4'b0100, 32'h0, 4'b0100);
    do_op("msubmin", MSUB, 2'd0, 64'd1, 32'hFFFF_FFFF, 4'b0010, 32'h0, 4'b0011);
    do_op("mfhi0", MFHI, 2'd0, 64'd0, 32'h7FFF_FFFF, 4'b0000, 32'h8000_0000, 4'b0001);

    // Out-of-range selector and NOP never produce a result.
    @(negedge clk);
    drive(1'b1, MULT, 2'd3, 64'h55);
    @(negedge clk);
    drive(1'b1, NOP, 2'd0, 64'h66);
    chk("badsel.busy", bus0.Busy, 1'b0);
    @(negedge clk);
    drive(1'b0, NOP, '0, '0);
    chk("badsel.ov", bus0.OutValid, 1'b0);
    chk("nop.busy", bus0.Busy, 1'b0);
    @(negedge clk);
    chk("nop.ov", bus0.OutValid, 1'b0);

    // Backpressure with two ops in flight and a third waiting.
    @(negedge clk);
    set_ready(1'b0);
    drive(1'b1, MULT, 2'd0, 64'h11);
    @(negedge clk);
    drive(1'b1, MADD, 2'd0, 64'h22);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("bp%0d.ov", i), bus0.OutValid, 1'b1);
      chk($sformatf("bp%0d.rdy", i), bus0.InReady, 1'b0);
      chk($sformatf("bp%0d.out0", i), bus0.Out, 32'h11);
      chk($sformatf("bp%0d.out1", i), bus1.Out, 32'h11);
      drive(1'b1, MFLO, 2'd0, 64'd0);
    end
    set_ready(1'b1);
    #1;
    chk("bp.rdy_rel", bus0.InReady, 1'b1);
    @(negedge clk);
    drive(1'b0, NOP, '0, '0);
    chk("bp.b.ov", bus0.OutValid, 1'b1);
    chk("bp.b.out", bus0.Out, 32'h33);
    chk("bp.b.fl", flg0(), 4'b0000);
    @(negedge clk);
    chk("bp.c.ov", bus0.OutValid, 1'b1);
    chk("bp.c.out0", bus0.Out, 32'h33);
    chk("bp.c.out1", bus1.Out, 32'h33);
    @(negedge clk);
    chk("bp.end.ov", bus0.OutValid, 1'b0);

    // Reset with two ops in flight and a request still presented.
    @(negedge clk);
    drive(1'b1, MULT, 2'd1, 64'h99);
    @(negedge clk);
    drive(1'b1, MULT, 2'd2, 64'h77);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    drive(1'b0, NOP, '0, '0);
    rst = 1'b0;
    chk("mrst.ov0", bus0.OutValid, 1'b0);
    chk("mrst.busy0", bus0.Busy, 1'b0);
    chk("mrst.out0", bus0.Out, 32'h0);
    chk("mrst.busy1", bus1.Busy, 1'b0);
    for (int k = 0; k < NACC; k++) begin
      do_op($sformatf("rhi%0d", k), MFHI, AW'(k), 64'd0, 32'h0, 4'b0100, 32'h0, 4'b0100);
      do_op($sformatf("rlo%0d", k), MFLO, AW'(k), 64'd0, 32'h0, 4'b0100, 32'h0, 4'b0100);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/acc_mac_unit.md
Name: acc_mac_unit

Overview:
- Parametrised successor to the single-accumulator EX2 path.
- A 2-stage pipelined multiply-accumulate back end. It holds NACC independent 2*DW-bit HI/LO accumulators and takes a 2*DW-bit product from the EX1 multiplier.
- It performs accumulate, subtract, move and clear operations with valid/ready flow control, optional saturation, per-accumulator forwarding and CZON flags.
- Sits in EX2, between the EX1 multiplier and the EX2 result/flag muxes.

Parameters:
- DW, 32, data word width; accumulators are 2*DW bits (HI = upper DW, LO = lower DW).
- NACC, 4, number of accumulators (≥1); AW = max(1,$clog2(NACC)).
- SAT, 0, 0 = wrap-around arithmetic, 1 = clamp accumulate results on overflow.

Ports:
- Clock    input   1      system clock, rising edge.
- Reset    input   1      synchronous, active-high reset.
- InValid  input   1      request valid.
- InReady  output  1      unit can accept a request this cycle.
- Op       input   4      acc_op_t operation code.
- AccSel   input   AW     target accumulator index.
- In       input   2*DW   product (MADD/MSUB/MULT) or move data in In[DW-1:0] (MTHI/MTLO).
- OutValid output  1      result valid.
- OutReady input   1      downstream accepts the result.
- Out      output  DW     result word.
- C, Z, O, N output 1 each  carry, zero, overflow, negative flags of the result.
- Busy     output  1      any stage occupied.

Behaviour:
- Reset is synchronous: on the Reset edge all accumulators are cleared to 0, both stage valids are cleared, and Out/C/Z/O/N/OutValid go to 0. Any in-flight ops are dropped. Reset overrides InValid.
- Accept occurs when InValid && InReady. InReady = !(S2 valid && !OutReady), i.e. the pipeline advances unless the output is held.
- Stage S1 registers Op, AccSel, In and reads the accumulator operand. Stage S2 computes, writes the accumulator and registers Out/flags.
- Latency: OutValid is asserted 2 cycles after accept. Throughput is 1 op/cycle.
- Backpressure: while OutValid && !OutReady, Out, flags and both stages hold, and no accumulator is written twice.
- Hazard: if S1 reads accumulator k while S2 writes k in the same cycle, S1 takes the S2 next-value through a bypass. No bubbles are inserted.
- Ops (acc_pkg::acc_op_t):
  - NOP: no write, OutValid is not asserted.
  - MULT: acc = In.
  - MADD/MADDU: acc = acc + In, signed/unsigned.
  - MSUB/MSUBU: acc = acc - In, signed/unsigned.
  - MTHI/MTLO: write the selected half from In[DW-1:0]; the other half is unchanged.
  - MFHI/MFLO: read the half, no write.
  - CLR: acc = 0.
- Out value: the selected half for MFHI/MFLO; otherwise LO of the new accumulator value.
- Flags for arithmetic ops are computed on the full 2*DW result:
  - Z = result == 0.
  - N = result MSB.
  - C = carry-out for add, borrow for subtract (unsigned ops only; 0 for signed).
  - O = signed overflow (signed ops only; 0 for unsigned).
- Flags for move/clear/MULT: C = O = 0; Z and N are taken from the Out word.
- SAT=1:
  - Signed overflow clamps to 0x7FF..F or 0x800..0.
  - Unsigned add overflow clamps to all-ones; unsigned subtract underflow clamps to 0.
  - The O or C flag is still reported.
- SAT=0: the result wraps modulo 2^(2*DW).
- AccSel ≥ NACC: the op is treated as NOP (no write, no output).
- Busy = S1 valid || S2 valid.

Decomposition:
- acc_pkg holds acc_op_t (4-bit enum: NOP, MULT, MADD, MADDU, MSUB, MSUBU, MTHI, MTLO, MFHI, MFLO, CLR) and default width constants.
- Sub-module acc_addsub: combinational 2*DW add/subtract with signed/unsigned mode, optional saturation, and C/O outputs.
- Top level holds the pipeline registers, accumulator array, bypass and handshake.

Test Plan:
- Back-to-back forwarding: DW=32. MULT acc0 In=0x0000_0001_0000_0000, then MADD acc0 In=1 on the next cycle, then MFLO and MFHI → Out = 0x00000001 then 0x00000001, OutValid 2 cycles after each accept with no gaps.
- Signed overflow, wrap: SAT=0, MTLO 0xFFFFFFFF and MTHI 0x7FFFFFFF on acc1, then MADD In=1 → HI = 0x80000000, LO = 0, O=1, N=1, Z=0.
- Signed overflow, clamp: same sequence with SAT=1 → acc1 = 0x7FFFFFFF_FFFFFFFF, O=1.
- Unsigned borrow and clamp: CLR acc2, then MSUBU In=5 → SAT=0: Out = 0xFFFFFFFB, C=1. SAT=1: Out = 0, Z=1, C=1.
- Backpressure: hold OutReady=0 for 3 cycles with 2 ops in flight → InReady=0 and Out stable. On release, results emerge in order, each exactly once.
- Reset mid-operation: assert Reset with 2 ops in flight → next cycle OutValid=0, Busy=0, and MFHI/MFLO on every accumulator return 0.
